riscv_jtag_dtm: RTL and testbench
=================================

# riscv_jtag_dtm

RISC-V Debug Transport Module (DTM) that sits directly downstream of the JTAG debug bridge. It consumes the target-side TCK/TMS/TDI/TRSTB lines and returns TDO. It implements a standard IEEE 1149.1 TAP with the RISC-V debug-spec 0.13 IDCODE, DTMCS, DMI and BYPASS registers. DMI scans become request/response transactions toward the debug module. Everything runs in the TCK domain; any CDC lives in the debug module.

## Interface
Parameters:
- IDCODE, 32'h1000_0CFD, value captured by the IDCODE register (bit 0 must be 1).
- ABITS, 7, DMI address width (1–63).

Ports:
- TCK  in  1  JTAG clock; sole clock of the block.
- TRSTB  in  1  Asynchronous, active-low reset (target-side TRST, inverted).
- TMS  in  1  Test mode select, sampled on TCK rising edge.
- TDI  in  1  Test data in, sampled on TCK rising edge.
- TDO  out  1  Test data out, launched on TCK falling edge.
- DMI_REQ_VALID  out  1  DMI request pending.
- DMI_REQ_READY  in  1  Debug module accepts the request.
- DMI_REQ_ADDR  out  ABITS  Request address.
- DMI_REQ_DATA  out  32  Write data.
- DMI_REQ_OP  out  2  1 = read, 2 = write.
- DMI_RESP_VALID  in  1  Response available.
- DMI_RESP_READY  out  1  DTM accepts the response.
- DMI_RESP_DATA  in  32  Read data.
- DMI_RESP_OP  in  2  0 = ok, 2 = failed, 3 = busy.

## Operation
- TAP FSM: 16 standard states, advanced on TCK rising edge per TMS. TRSTB low forces TEST_LOGIC_RESET asynchronously. Five TMS=1 clocks reach TEST_LOGIC_RESET from any state.
- IR: 5 bits. CAPTURE_IR loads 5'b00001. UPDATE_IR latches the shift register. TEST_LOGIC_RESET sets IR = 0x01.
- IR decode: 0x01 IDCODE (32b); 0x10 DTMCS (32b); 0x11 DMI (ABITS+34 b); all other codes select BYPASS (1b, captures 0).
- Shifting: LSB first. In SHIFT_xR, TDI enters the MSB and the LSB feeds TDO.
- DTMCS capture value:
  - version[3:0] = 1
  - abits[9:4] = ABITS
  - dmistat[11:10] = sticky status
  - idle[14:12] = 1
  - all other bits 0
- DTMCS update: bit16 (dmireset) clears sticky status. Bit17 (dmihardreset) clears sticky status, clears outstanding and drops DMI_REQ_VALID, and discards the pending response.
- DMI register layout: {addr[ABITS+33:34], data[33:2], op[1:0]}.
- DMI capture:
  - Captures {last_addr, resp_data, status}.
  - status = sticky if sticky ≠ 0.
  - Otherwise status = 3 if a transaction is outstanding; in that case sticky is also set to 3.
  - Otherwise status = 0.
- DMI update with op 1 or 2:
  - Issue a request only if sticky = 0 and nothing is outstanding. Latch addr/data/op and set outstanding.
  - If outstanding, set sticky = 3 and issue nothing.
  - If sticky ≠ 0, issue nothing.
  - Op 0 or 3 is a no-op.
- Response: DMI_RESP_READY = outstanding & ~DMI_REQ_VALID. On RESP_VALID & RESP_READY:
  - resp_data ← DMI_RESP_DATA.
  - Clear outstanding.
  - If RESP_OP = 2 or 3 and sticky = 0, sticky ← RESP_OP.
- Write responses also update resp_data.

## Timing
- Reset values (TRSTB low):
  - TDO = 0, DMI_REQ_VALID = 0, DMI_RESP_READY = 0.
  - DMI_REQ_ADDR/DATA/OP = 0.
  - IR = 0x01, sticky = 0, outstanding = 0, resp_data = 0, last_addr = 0.
- TDO: updated on TCK falling edge from the shift-register LSB while in SHIFT_IR/SHIFT_DR; otherwise 0.
- Request launch: DMI_REQ_VALID rises on the rising edge that leaves UPDATE_DR. Payload is held stable until the edge with VALID & READY; VALID falls on that edge. READY high at launch gives a 1-cycle pulse.
- DMI_RESP_READY rises the edge after request acceptance and falls the edge the response is taken. Minimum round trip is 2 TCK after launch.
- Simultaneous response arrival and UPDATE_DR on the same edge: the update sees outstanding = 1, so sticky = 3 and the new scan is dropped; the response is still consumed.
- Simultaneous dmihardreset update and response on the same edge: hardreset wins and the response is not recorded.
- TRSTB low mid-transaction: immediate abort. A response arriving after reset is ignored because RESP_READY = 0.

## Test plan
- TRSTB pulse, then shift DR 32 bits from RUN_TEST_IDLE → TDO yields IDCODE 0x10000CFD LSB first; IR reads back 5'b00001 on IR capture.
- Load IR = 0x10, scan DTMCS with zeros → captured 0x00001071 (ABITS = 7); DTMCS is unaffected by the write.
- DMI write addr 0x10, data 0x00000001, op 2; debug module model: READY after 3 TCK, response op 0 → one VALID&READY handshake with exact payload; next DMI scan captures op 0, addr 0x10.
- DMI read addr 0x11; response data 0xDEADBEEF op 0 → following DMI capture shifts out data 0xDEADBEEF, op 0.
- Second DMI update while the first response is withheld → capture returns op 3, sticky = 3, no second request. DTMCS dmireset then clears sticky; a new scan succeeds.
- Response op 2, then IR = 0x07 (bypass) → dmistat = 2 persists. Bypass delays TDI by exactly 1 TCK. dmihardreset with a pending request → DMI_REQ_VALID drops the next edge.

Source files
------------

// File: rtl/riscv_jtag_dtm.sv
// RISC-V debug transport module: IEEE 1149.1 TAP exposing IDCODE, DTMCS, DMI and BYPASS,
// turning DMI scans into request/response transactions toward the debug module.
module riscv_jtag_dtm #(
  parameter logic [31:0] IDCODE = 32'h1000_0CFD,
  parameter int unsigned ABITS  = 7
) (
  input  logic             TCK,
  input  logic             TRSTB,
  input  logic             TMS,
  input  logic             TDI,
  output logic             TDO,
  output logic             DMI_REQ_VALID,
  input  logic             DMI_REQ_READY,
  output logic [ABITS-1:0] DMI_REQ_ADDR,
  output logic [31:0]      DMI_REQ_DATA,
  output logic [1:0]       DMI_REQ_OP,
  input  logic             DMI_RESP_VALID,
  output logic             DMI_RESP_READY,
  input  logic [31:0]      DMI_RESP_DATA,
  input  logic [1:0]       DMI_RESP_OP
);

  localparam int unsigned DRW       = ABITS + 34;
  localparam logic [4:0]  IR_IDCODE = 5'h01;
  localparam logic [4:0]  IR_DTMCS  = 5'h10;
  localparam logic [4:0]  IR_DMI    = 5'h11;

  typedef enum logic [3:0] {
    S_TLR, S_RTI, S_SEL_DR, S_CAP_DR, S_SHIFT_DR, S_EXIT1_DR, S_PAUSE_DR, S_EXIT2_DR,
    S_UPD_DR, S_SEL_IR, S_CAP_IR, S_SHIFT_IR, S_EXIT1_IR, S_PAUSE_IR, S_EXIT2_IR, S_UPD_IR
  } tap_state_t;

  tap_state_t       r_state;
  logic [4:0]       r_ir;
  logic [4:0]       r_ir_sh;
  logic [DRW-1:0]   r_dr;
  logic [1:0]       r_sticky;
  logic             r_outstanding;
  logic [31:0]      r_resp_data;
  logic [ABITS-1:0] r_last_addr;
  logic             r_req_valid;
  logic [ABITS-1:0] r_req_addr;
  logic [31:0]      r_req_data;
  logic [1:0]       r_req_op;

  always_ff @(posedge TCK or negedge TRSTB) begin
    if (!TRSTB) begin
      r_state <= S_TLR;
    end else begin
      case (r_state)
        S_TLR:      r_state <= TMS ? S_TLR      : S_RTI;
        S_RTI:      r_state <= TMS ? S_SEL_DR   : S_RTI;
        S_SEL_DR:   r_state <= TMS ? S_SEL_IR   : S_CAP_DR;
        S_CAP_DR:   r_state <= TMS ? S_EXIT1_DR : S_SHIFT_DR;
        S_SHIFT_DR: r_state <= TMS ? S_EXIT1_DR : S_SHIFT_DR;
        S_EXIT1_DR: r_state <= TMS ? S_UPD_DR   : S_PAUSE_DR;
        S_PAUSE_DR: r_state <= TMS ? S_EXIT2_DR : S_PAUSE_DR;
        S_EXIT2_DR: r_state <= TMS ? S_UPD_DR   : S_SHIFT_DR;
        S_UPD_DR:   r_state <= TMS ? S_SEL_DR   : S_RTI;
        S_SEL_IR:   r_state <= TMS ? S_TLR      : S_CAP_IR;
        S_CAP_IR:   r_state <= TMS ? S_EXIT1_IR : S_SHIFT_IR;
        S_SHIFT_IR: r_state <= TMS ? S_EXIT1_IR : S_SHIFT_IR;
        S_EXIT1_IR: r_state <= TMS ? S_UPD_IR   : S_PAUSE_IR;
        S_PAUSE_IR: r_state <= TMS ? S_EXIT2_IR : S_PAUSE_IR;
        S_EXIT2_IR: r_state <= TMS ? S_UPD_IR   : S_SHIFT_IR;
        S_UPD_IR:   r_state <= TMS ? S_SEL_DR   : S_RTI;
        default:    r_state <= S_TLR;
      endcase
    end
  end

  logic        w_sel_idcode, w_sel_dtmcs, w_sel_dmi;
  logic        w_cap_dr, w_upd_dr;
  logic [1:0]  w_dmi_status;
  logic [31:0] w_dtmcs;
  logic        w_dmi_access, w_dmireset, w_hardreset;
  logic        w_req_fire, w_resp_fire;

  assign w_sel_idcode = (r_ir == IR_IDCODE);
  assign w_sel_dtmcs  = (r_ir == IR_DTMCS);
  assign w_sel_dmi    = (r_ir == IR_DMI);
  assign w_cap_dr     = (r_state == S_CAP_DR);
  assign w_upd_dr     = (r_state == S_UPD_DR);
  assign w_dmi_status = (r_sticky != 2'd0) ? r_sticky : (r_outstanding ? 2'd3 : 2'd0);
  assign w_dtmcs      = {17'd0, 3'd1, r_sticky, 6'(ABITS), 4'd1};
  assign w_dmi_access = w_upd_dr && w_sel_dmi && (r_dr[1:0] == 2'd1 || r_dr[1:0] == 2'd2);
  assign w_dmireset   = w_upd_dr && w_sel_dtmcs && r_dr[16];
  assign w_hardreset  = w_upd_dr && w_sel_dtmcs && r_dr[17];
  assign w_req_fire   = r_req_valid && DMI_REQ_READY;
  assign w_resp_fire  = DMI_RESP_VALID && DMI_RESP_READY;

  // One shared DR shift register; TDI enters at the MSB of whichever register is selected.
  always_ff @(posedge TCK or negedge TRSTB) begin
    if (!TRSTB) begin
      r_ir    <= IR_IDCODE;
      r_ir_sh <= 5'd0;
      r_dr    <= '0;
    end else begin
      case (r_state)
        S_TLR:      r_ir    <= IR_IDCODE;
        S_CAP_IR:   r_ir_sh <= 5'b00001;
        S_SHIFT_IR: r_ir_sh <= {TDI, r_ir_sh[4:1]};
        S_UPD_IR:   r_ir    <= r_ir_sh;
        S_CAP_DR: begin
          if (w_sel_dmi)         r_dr <= {r_last_addr, r_resp_data, w_dmi_status};
          else if (w_sel_idcode) r_dr <= DRW'(IDCODE);
          else if (w_sel_dtmcs)  r_dr <= DRW'(w_dtmcs);
          else                   r_dr <= '0;
        end
        S_SHIFT_DR: begin
          if (w_sel_dmi)                        r_dr <= {TDI, r_dr[DRW-1:1]};
          else if (w_sel_idcode || w_sel_dtmcs) r_dr <= DRW'({TDI, r_dr[31:1]});
          else                                  r_dr <= DRW'(TDI);
        end
        default: ;
      endcase
    end
  end

  // Later assignments win: the update's busy marking beats a same-edge failed response,
  // and dmihardreset beats everything.
  always_ff @(posedge TCK or negedge TRSTB) begin
    if (!TRSTB) begin
      r_sticky      <= 2'd0;
      r_outstanding <= 1'b0;
      r_resp_data   <= 32'd0;
      r_last_addr   <= '0;
      r_req_valid   <= 1'b0;
      r_req_addr    <= '0;
      r_req_data    <= 32'd0;
      r_req_op      <= 2'd0;
    end else begin
      if (w_req_fire) r_req_valid <= 1'b0;
      if (w_resp_fire && !w_hardreset) begin
        r_resp_data   <= DMI_RESP_DATA;
        r_outstanding <= 1'b0;
        if (DMI_RESP_OP[1] && r_sticky == 2'd0) r_sticky <= DMI_RESP_OP;
      end
      if (w_cap_dr && w_sel_dmi && r_sticky == 2'd0 && r_outstanding) r_sticky <= 2'd3;
      if (w_dmi_access) begin
        if (r_outstanding) begin
          r_sticky <= 2'd3;
        end else if (r_sticky == 2'd0) begin
          r_req_valid   <= 1'b1;
          r_outstanding <= 1'b1;
          r_req_addr    <= r_dr[DRW-1:34];
          r_req_data    <= r_dr[33:2];
          r_req_op      <= r_dr[1:0];
          r_last_addr   <= r_dr[DRW-1:34];
        end
      end
      if (w_dmireset) r_sticky <= 2'd0;
      if (w_hardreset) begin
        r_sticky      <= 2'd0;
        r_outstanding <= 1'b0;
        r_req_valid   <= 1'b0;
      end
    end
  end

  always_ff @(negedge TCK or negedge TRSTB) begin
    if (!TRSTB)                    TDO <= 1'b0;
    else if (r_state == S_SHIFT_IR) TDO <= r_ir_sh[0];
    else if (r_state == S_SHIFT_DR) TDO <= r_dr[0];
    else                           TDO <= 1'b0;
  end

  assign DMI_REQ_VALID  = r_req_valid;
  assign DMI_REQ_ADDR   = r_req_addr;
  assign DMI_REQ_DATA   = r_req_data;
  assign DMI_REQ_OP     = r_req_op;
  assign DMI_RESP_READY = r_outstanding && !r_req_valid;

endmodule

// File: tb/tb_riscv_jtag_dtm.sv
// Scoreboard bench for riscv_jtag_dtm: driver pushes expected scan-outs and DMI requests,
// monitors pop and compare as the DUT shifts data out or handshakes a request.
module tb_riscv_jtag_dtm;

  logic        TCK = 1'b0;
  logic        TRSTB, TMS, TDI, TDO;
  logic        DMI_REQ_VALID, DMI_REQ_READY;
  logic [6:0]  DMI_REQ_ADDR;
  logic [31:0] DMI_REQ_DATA;
  logic [1:0]  DMI_REQ_OP;
  logic        DMI_RESP_VALID, DMI_RESP_READY;
  logic [31:0] DMI_RESP_DATA;
  logic [1:0]  DMI_RESP_OP;

  riscv_jtag_dtm #(.IDCODE(32'h1000_0CFD), .ABITS(7)) dut (
    .TCK(TCK), .TRSTB(TRSTB), .TMS(TMS), .TDI(TDI), .TDO(TDO),
    .DMI_REQ_VALID(DMI_REQ_VALID), .DMI_REQ_READY(DMI_REQ_READY),
    .DMI_REQ_ADDR(DMI_REQ_ADDR), .DMI_REQ_DATA(DMI_REQ_DATA), .DMI_REQ_OP(DMI_REQ_OP),
    .DMI_RESP_VALID(DMI_RESP_VALID), .DMI_RESP_READY(DMI_RESP_READY),
    .DMI_RESP_DATA(DMI_RESP_DATA), .DMI_RESP_OP(DMI_RESP_OP)
  );

  always #5 TCK = ~TCK;

  typedef enum int {
    T_TLR, T_RTI, T_SEL_DR, T_CAP_DR, T_SHIFT_DR, T_EXIT1_DR, T_PAUSE_DR, T_EXIT2_DR,
    T_UPD_DR, T_SEL_IR, T_CAP_IR, T_SHIFT_IR, T_EXIT1_IR, T_PAUSE_IR, T_EXIT2_IR, T_UPD_IR
  } tstate_t;

  typedef struct { logic [63:0] val; int len; } scan_t;
  typedef struct { logic [6:0] addr; logic [31:0] data; logic [1:0] op; } req_t;

  scan_t exp_scan[$];
  string exp_name[$];
  req_t  exp_req[$];

  int checks = 0;
  int errors = 0;
  int resp_hs_count = 0;
  int req_hs_count = 0;

  int          dm_delay = 3;
  logic        dm_hold = 1'b0;
  logic [31:0] dm_resp_data = 32'd0;
  logic [1:0]  dm_resp_op = 2'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic tstate_t tap_next(input tstate_t s, input logic tms);
    case (s)
      T_TLR:      return tms ? T_TLR      : T_RTI;
      T_RTI:      return tms ? T_SEL_DR   : T_RTI;
      T_SEL_DR:   return tms ? T_SEL_IR   : T_CAP_DR;
      T_CAP_DR:   return tms ? T_EXIT1_DR : T_SHIFT_DR;
      T_SHIFT_DR: return tms ? T_EXIT1_DR : T_SHIFT_DR;
      T_EXIT1_DR: return tms ? T_UPD_DR   : T_PAUSE_DR;
      T_PAUSE_DR: return tms ? T_EXIT2_DR : T_PAUSE_DR;
      T_EXIT2_DR: return tms ? T_UPD_DR   : T_SHIFT_DR;
      T_UPD_DR:   return tms ? T_SEL_DR   : T_RTI;
      T_SEL_IR:   return tms ? T_TLR      : T_CAP_IR;
      T_CAP_IR:   return tms ? T_EXIT1_IR : T_SHIFT_IR;
      T_SHIFT_IR: return tms ? T_EXIT1_IR : T_SHIFT_IR;
      T_EXIT1_IR: return tms ? T_UPD_IR   : T_PAUSE_IR;
      T_PAUSE_IR: return tms ? T_EXIT2_IR : T_PAUSE_IR;
      T_EXIT2_IR: return tms ? T_UPD_IR   : T_SHIFT_IR;
      default:    return tms ? T_SEL_DR   : T_RTI;
    endcase
  endfunction

  function automatic logic [63:0] dmi(input logic [6:0] a, input logic [31:0] d, input logic [1:0] o);
    return {23'd0, a, d, o};
  endfunction

  // Monitor: samples 1 time unit after the falling edge, i.e. the values the next rising edge uses.
  tstate_t     mstate = T_TLR;
  logic [63:0] acc = '0;
  int          cnt = 0;
  initial begin
    forever begin
      @(negedge TCK);
      #1;
      if (TRSTB !== 1'b1) begin
        mstate = T_TLR;
        cnt = 0;
        acc = '0;
      end else begin
        if (DMI_REQ_VALID && DMI_REQ_READY) begin
          req_hs_count++;
          if (exp_req.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got addr %h data %h op %0d, required none",
                     DMI_REQ_ADDR, DMI_REQ_DATA, DMI_REQ_OP);
          end else begin
            req_t r;
            r = exp_req.pop_front();
            chk("dmi_req_payload", {23'd0, DMI_REQ_ADDR, DMI_REQ_DATA, DMI_REQ_OP},
                dmi(r.addr, r.data, r.op));
          end
        end
        if (DMI_RESP_VALID && DMI_RESP_READY) resp_hs_count++;
        if (mstate == T_SHIFT_DR || mstate == T_SHIFT_IR) begin
          acc[cnt] = TDO;
          cnt++;
        end
        begin
          tstate_t nxt;
          nxt = tap_next(mstate, TMS);
          if ((mstate == T_SHIFT_DR || mstate == T_SHIFT_IR) && nxt != mstate) begin
            if (exp_scan.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_scan: got %h, required no scan", acc);
            end else begin
              scan_t e;
              string n;
              e = exp_scan.pop_front();
              n = exp_name.pop_front();
              chk({n, "_len"}, 64'(cnt), 64'(e.len));
              chk(n, acc & ((64'd1 << e.len) - 64'd1), e.val);
            end
            cnt = 0;
            acc = '0;
          end
          mstate = nxt;
        end
      end
    end
  end

  // Debug module model: READY after dm_delay cycles, then one response (unless withheld).
  initial begin
    int   wcnt;
    logic pend, vq, rq;
    DMI_REQ_READY = 1'b0; DMI_RESP_VALID = 1'b0; DMI_RESP_DATA = 32'd0; DMI_RESP_OP = 2'd0;
    wcnt = 0; pend = 1'b0; vq = 1'b0; rq = 1'b0;
    forever begin
      @(negedge TCK);
      if (TRSTB !== 1'b1) begin
        DMI_REQ_READY = 1'b0; DMI_RESP_VALID = 1'b0;
        wcnt = 0; pend = 1'b0; vq = 1'b0; rq = 1'b0;
      end else begin
        if (DMI_REQ_READY) begin
          if (vq) pend = 1'b1;
          DMI_REQ_READY = 1'b0;
          wcnt = 0;
        end else if (DMI_REQ_VALID) begin
          wcnt++;
          if (wcnt >= dm_delay) DMI_REQ_READY = 1'b1;
        end else begin
          wcnt = 0;
        end
        if (DMI_RESP_VALID && rq) begin
          DMI_RESP_VALID = 1'b0;
        end else if (pend && !dm_hold && !DMI_RESP_VALID) begin
          DMI_RESP_VALID = 1'b1;
          DMI_RESP_DATA  = dm_resp_data;
          DMI_RESP_OP    = dm_resp_op;
          pend = 1'b0;
        end
        vq = DMI_REQ_VALID;
        rq = DMI_RESP_READY;
      end
    end
  end

  task automatic jclk(input logic tms, input logic tdi);
    @(negedge TCK);
    TMS = tms;
    TDI = tdi;
  endtask

  task automatic scan_ir(input logic [4:0] code, input string name);
    exp_scan.push_back('{val: 64'h01, len: 5});
    exp_name.push_back(name);
    jclk(1, 0); jclk(1, 0); jclk(0, 0); jclk(0, 0);
    for (int i = 0; i < 5; i++) jclk(i == 4, code[i]);
    jclk(1, 0); jclk(0, 0);
  endtask

  task automatic scan_dr(input int len, input logic [63:0] din, input logic [63:0] exp, input string name);
    exp_scan.push_back('{val: exp, len: len});
    exp_name.push_back(name);
    jclk(1, 0); jclk(0, 0); jclk(0, 0);
    for (int i = 0; i < len; i++) jclk(i == len - 1, din[i]);
    jclk(1, 0); jclk(0, 0);
  endtask

  task automatic run_until_resp(input int target, input string name);
    for (int i = 0; i < 60 && resp_hs_count < target; i++) jclk(0, 0);
    chk(name, 64'(resp_hs_count), 64'(target));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    TRSTB = 1'b0; TMS = 1'b1; TDI = 1'b0;
    repeat (3) @(negedge TCK);
    #1;
    chk("rst_tdo", 64'(TDO), 64'd0);
    chk("rst_req_valid", 64'(DMI_REQ_VALID), 64'd0);
    chk("rst_resp_ready", 64'(DMI_RESP_READY), 64'd0);
    chk("rst_req_payload", dmi(DMI_REQ_ADDR, DMI_REQ_DATA, DMI_REQ_OP), 64'd0);
    @(negedge TCK);
    TRSTB = 1'b1;
    jclk(0, 0);

    scan_dr(32, 64'd0, 64'h1000_0CFD, "idcode");
    scan_ir(5'h10, "ir_dtmcs");
    scan_dr(32, 64'd0, 64'h0000_1071, "dtmcs_cap");
    scan_dr(32, 64'd0, 64'h0000_1071, "dtmcs_after_wr");

    scan_ir(5'h11, "ir_dmi");
    dm_resp_data = 32'd0; dm_resp_op = 2'd0;
    exp_req.push_back('{addr: 7'h10, data: 32'h1, op: 2'd2});
    scan_dr(41, dmi(7'h10, 32'h1, 2'd2), 64'd0, "dmi_wr10");
    run_until_resp(1, "resp_wr10");
    scan_dr(41, 64'd0, dmi(7'h10, 32'h0, 2'd0), "dmi_cap_wr10");

    dm_resp_data = 32'hDEAD_BEEF;
    exp_req.push_back('{addr: 7'h11, data: 32'h0, op: 2'd1});
    scan_dr(41, dmi(7'h11, 32'h0, 2'd1), dmi(7'h10, 32'h0, 2'd0), "dmi_rd11");
    run_until_resp(2, "resp_rd11");
    scan_dr(41, 64'd0, dmi(7'h11, 32'hDEAD_BEEF, 2'd0), "dmi_cap_rd11");

    dm_hold = 1'b1; dm_resp_data = 32'h1234_5678;
    exp_req.push_back('{addr: 7'h12, data: 32'hA5A5_A5A5, op: 2'd2});
    scan_dr(41, dmi(7'h12, 32'hA5A5_A5A5, 2'd2), dmi(7'h11, 32'hDEAD_BEEF, 2'd0), "dmi_wr12");
    scan_dr(41, dmi(7'h13, 32'h5, 2'd2), dmi(7'h12, 32'hDEAD_BEEF, 2'd3), "dmi_busy1");
    scan_dr(41, 64'd0, dmi(7'h12, 32'hDEAD_BEEF, 2'd3), "dmi_busy2");
    dm_hold = 1'b0;
    run_until_resp(3, "resp_wr12");
    scan_ir(5'h10, "ir_dtmcs2");
    scan_dr(32, 64'h1_0000, 64'h0000_1C71, "dtmcs_sticky3");
    scan_dr(32, 64'd0, 64'h0000_1071, "dtmcs_cleared");

    scan_ir(5'h11, "ir_dmi2");
    dm_resp_data = 32'd0;
    exp_req.push_back('{addr: 7'h14, data: 32'h77, op: 2'd2});
    scan_dr(41, dmi(7'h14, 32'h77, 2'd2), dmi(7'h12, 32'h1234_5678, 2'd0), "dmi_wr14");
    run_until_resp(4, "resp_wr14");

    dm_resp_data = 32'hBAD0_BAD0; dm_resp_op = 2'd2;
    exp_req.push_back('{addr: 7'h15, data: 32'h0, op: 2'd1});
    scan_dr(41, dmi(7'h15, 32'h0, 2'd1), dmi(7'h14, 32'h0, 2'd0), "dmi_rd15");
    run_until_resp(5, "resp_rd15");
    dm_resp_op = 2'd0;

    scan_ir(5'h07, "ir_bypass");
    scan_dr(8, 64'hB2, 64'h64, "bypass");
    scan_ir(5'h10, "ir_dtmcs3");
    scan_dr(32, 64'h1_0000, 64'h0000_1871, "dtmcs_sticky2");

    scan_ir(5'h11, "ir_dmi3");
    dm_delay = 1000;
    scan_dr(41, dmi(7'h16, 32'h0, 2'd1), dmi(7'h15, 32'hBAD0_BAD0, 2'd0), "dmi_rd16");
    scan_ir(5'h10, "ir_dtmcs4");
    chk("req_pending", 64'(DMI_REQ_VALID), 64'd1);
    scan_dr(32, 64'h2_0000, 64'h0000_1071, "dtmcs_hardreset");
    chk("req_before_hr_edge", 64'(DMI_REQ_VALID), 64'd1);
    @(posedge TCK);
    #1;
    chk("req_after_hr_edge", 64'(DMI_REQ_VALID), 64'd0);
    chk("resp_ready_after_hr", 64'(DMI_RESP_READY), 64'd0);

    dm_delay = 1; dm_resp_data = 32'h0000_0042;
    scan_ir(5'h11, "ir_dmi4");
    exp_req.push_back('{addr: 7'h17, data: 32'hCAFE, op: 2'd2});
    scan_dr(41, dmi(7'h17, 32'hCAFE, 2'd2), dmi(7'h16, 32'hBAD0_BAD0, 2'd0), "dmi_wr17");
    run_until_resp(6, "resp_wr17");
    scan_dr(41, 64'd0, dmi(7'h17, 32'h42, 2'd0), "dmi_cap_wr17");

    repeat (5) jclk(0, 0);
    chk("req_handshakes", 64'(req_hs_count), 64'd6);
    chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
    chk("scan_queue_empty", 64'(exp_scan.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
